// File: rtl/gmii_tx_arbiter.sv
// Round-robin frame arbiter in front of a single GMII transmit port.
// Owns the wire for a whole frame, enforces an inter-frame gap, and flags underrun and oversize frames.
module gmii_tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_BYTES  = 1526
) (
    input  logic                 gmii_tx_clk,
    input  logic                 reset,
    input  logic                 link_up,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           gmii_txd,
    output logic                 gmii_tx_en,
    output logic                 gmii_tx_er,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_underrun,
    output logic                 err_oversize
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DROP, IFG} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PW-1:0]      gidx_q;
    logic [PW-1:0]      ptr_q;
    logic [10:0]        byte_cnt_q;
    logic [IW-1:0]      ifg_cnt_q;
    logic [7:0]         txd_q;
    logic               tx_en_q;
    logic               tx_er_q;
    logic               frame_done_q;
    logic               err_underrun_q;
    logic               err_oversize_q;

    logic               sel_found_d;
    logic [PW-1:0]      sel_idx_d;
    logic [PW:0]        cand_d;
    logic [PW-1:0]      ptr_d;
    logic               g_valid;
    logic               g_last;
    logic [7:0]         g_data;
    logic               accepting;

    // Scan from the pointer downwards so the lowest offset from the pointer wins.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        cand_d      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_d = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand_d >= (PW+1)'(NUM_REQ)) begin
                cand_d = cand_d - (PW+1)'(NUM_REQ);
            end
            if (req_valid[cand_d[PW-1:0]]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = cand_d[PW-1:0];
            end
        end
    end

    assign ptr_d     = (sel_idx_d == PW'(NUM_REQ - 1)) ? '0 : sel_idx_d + 1'b1;
    assign g_valid   = req_valid[gidx_q];
    assign g_last    = req_last[gidx_q];
    assign g_data    = req_data[{gidx_q, 3'b000} +: 8];
    assign accepting = (state_q == SEND) || (state_q == DROP);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_q[gi] & accepting;
        end
    endgenerate

    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            gidx_q         <= '0;
            ptr_q          <= '0;
            byte_cnt_q     <= '0;
            ifg_cnt_q      <= '0;
            txd_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            frame_done_q   <= 1'b0;
            err_underrun_q <= 1'b0;
            err_oversize_q <= 1'b0;
        end else begin
            txd_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            frame_done_q   <= 1'b0;
            err_underrun_q <= 1'b0;
            err_oversize_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (link_up && sel_found_d) begin
                        grant_q    <= NUM_REQ'(1) << sel_idx_d;
                        gidx_q     <= sel_idx_d;
                        ptr_q      <= ptr_d;
                        byte_cnt_q <= '0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (g_valid) begin
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                        txd_q      <= g_data;
                        tx_en_q    <= 1'b1;
                        if (g_last) begin
                            frame_done_q <= 1'b1;
                            ifg_cnt_q    <= '0;
                            state_q      <= IFG;
                        end else if (byte_cnt_q == 11'(MAX_BYTES - 1)) begin
                            tx_er_q        <= 1'b1;
                            err_oversize_q <= 1'b1;
                            state_q        <= DROP;
                        end
                    end else begin
                        // Source ran dry mid-frame: poison the wire with an error symbol.
                        tx_en_q        <= 1'b1;
                        tx_er_q        <= 1'b1;
                        err_underrun_q <= 1'b1;
                        state_q        <= DROP;
                    end
                end
                DROP: begin
                    if (g_valid && g_last) begin
                        ifg_cnt_q <= '0;
                        state_q   <= IFG;
                    end
                end
                IFG: begin
                    if (ifg_cnt_q == IW'(IFG_CYCLES - 1)) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        ifg_cnt_q <= ifg_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant        = grant_q;
    assign gmii_txd     = txd_q;
    assign gmii_tx_en   = tx_en_q;
    assign gmii_tx_er   = tx_er_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = frame_done_q;
    assign err_underrun = err_underrun_q;
    assign err_oversize = err_oversize_q;
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: per-requester byte sources, a scoreboard of
// expected wire beats, and a monitor that pops and compares every transmitted beat.
module tb_gmii_tx_arbiter;
    localparam int MAXB = 100;

    logic        clk = 1'b0;
    always #4 clk = ~clk;

    logic        reset;
    logic        link_up;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        frame_done;
    logic        err_underrun;
    logic        err_oversize;

    gmii_tx_arbiter #(
        .NUM_REQ   (2),
        .IFG_CYCLES(12),
        .MAX_BYTES (MAXB)
    ) dut (
        .gmii_tx_clk (clk),
        .reset       (reset),
        .link_up     (link_up),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_underrun(err_underrun),
        .err_oversize(err_oversize)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } src_t;

    typedef struct packed {
        logic [1:0] grant;
        logic       er;
        logic [7:0] txd;
        logic       done;
        logic       eu;
        logic       eo;
    } beat_t;

    src_t  src0[$];
    src_t  src1[$];
    beat_t sb[$];
    int    gaps[$];
    int    checks   = 0;
    int    failures = 0;
    int    beats    = 0;
    int    low_run  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_val(input int i, input int seed);
        if (i <= 7) return 8'h55;
        if (i == 8) return 8'hD5;
        return 8'(i * 13 + seed * 29);
    endfunction

    task automatic queue_src(input int r, input int n, input int stall, input int seed);
        src_t e;
        for (int i = 1; i <= n; i++) begin
            e.data = byte_val(i, seed);
            e.last = (i == n);
            e.gap  = (i == stall) ? 3 : 0;
            if (r == 0) src0.push_back(e);
            else        src1.push_back(e);
        end
    endtask

    task automatic expect_frame(input int r, input int n, input int stall, input int seed);
        beat_t b;
        for (int i = 1; i <= n; i++) begin
            b.grant = 2'(1 << r);
            b.er    = 1'b0;
            b.txd   = byte_val(i, seed);
            b.done  = (i == n);
            b.eu    = 1'b0;
            b.eo    = 1'b0;
            if (i == stall) begin
                b.er = 1'b1; b.txd = 8'h00; b.done = 1'b0; b.eu = 1'b1;
                sb.push_back(b);
                break;
            end
            if (i == MAXB && n > MAXB) begin
                b.er = 1'b1; b.done = 1'b0; b.eo = 1'b1;
                sb.push_back(b);
                break;
            end
            sb.push_back(b);
        end
        $display("queued expected frame: req=%0d bytes=%0d stall_at=%0d seed=%0d", r, n, stall, seed);
    endtask

    task automatic present(input int r);
        src_t e;
        bit   have;
        have = 1'b0;
        e.data = 8'h00; e.last = 1'b0; e.gap = 0;
        if (r == 0 && src0.size() > 0) begin e = src0[0]; have = 1'b1; end
        if (r == 1 && src1.size() > 0) begin e = src1[0]; have = 1'b1; end
        if (have && e.gap > 0) begin
            e.gap--;
            have = 1'b0;
            if (r == 0) src0[0] = e;
            else        src1[0] = e;
        end
        req_valid[r]       = have;
        req_data[8*r +: 8] = have ? e.data : 8'h00;
        req_last[r]        = have & e.last;
    endtask

    // Source driver: present at the falling edge, retire a byte once valid&ready is seen.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            present(0);
            present(1);
            #1;
            if (req_valid[0] && req_ready[0] && src0.size() > 0) void'(src0.pop_front());
            if (req_valid[1] && req_ready[1] && src1.size() > 0) void'(src1.pop_front());
        end
    end

    // Wire monitor: every tx_en beat is matched against the scoreboard head.
    initial begin
        beat_t exp_b;
        forever begin
            @(negedge clk);
            if (gmii_tx_en === 1'b1) begin
                if (low_run > 0) gaps.push_back(low_run);
                low_run = 0;
                check("beat_expected", 32'(gmii_tx_en), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    exp_b = sb.pop_front();
                    check("beat", {18'b0, grant, gmii_tx_er, gmii_txd, frame_done, err_underrun, err_oversize},
                          32'(exp_b));
                    beats++;
                end
            end else begin
                low_run++;
                check("idle_quiet", {27'b0, gmii_tx_en, gmii_tx_er, frame_done, err_underrun, err_oversize}, 32'd0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int k;
        k = 0;
        while (sb.size() != 0 && k < limit) begin
            cycles(1);
            k++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        $display("drain %s: remaining=%0d after %0d cycles", tag, sb.size(), k);
    endtask

    task automatic wait_beats(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (beats < n && k < limit) begin
            cycles(1);
            k++;
        end
        check(tag, 32'(beats >= n), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        link_up = 1'b1;
        cycles(3);
        check("reset_outputs", {14'b0, grant, req_ready, gmii_txd, gmii_tx_en, gmii_tx_er, busy,
                                frame_done, err_underrun, err_oversize}, 32'd0);
        reset = 1'b0;
        cycles(2);

        // Contention: both requesters loaded, grants must alternate 0,1,0,1 with 13-cycle gaps.
        gaps.delete();
        queue_src(0, 64, 0, 1);
        queue_src(0, 64, 0, 2);
        queue_src(1, 64, 0, 3);
        queue_src(1, 64, 0, 4);
        expect_frame(0, 64, 0, 1);
        expect_frame(1, 64, 0, 3);
        expect_frame(0, 64, 0, 2);
        expect_frame(1, 64, 0, 4);
        wait_drain("contention_drain", 600);
        check("gap_count", 32'(gaps.size()), 32'd4);
        if (gaps.size() >= 4) begin
            for (int i = 1; i < 4; i++) check("ifg_gap", 32'(gaps[i]), 32'd13);
        end
        cycles(16);

        // Single 68-byte frame; grant held through the IFG and released right after it.
        queue_src(0, 68, 0, 5);
        expect_frame(0, 68, 0, 5);
        wait_drain("single_drain", 200);
        check("ifg_first", {29'b0, grant, busy}, {29'b0, 2'b01, 1'b1});
        cycles(11);
        check("ifg_last", {29'b0, grant, busy}, {29'b0, 2'b01, 1'b1});
        cycles(1);
        check("ifg_release", {29'b0, grant, busy}, 32'd0);
        cycles(4);

        // Underrun: requester 1 stalls for 3 cycles before byte 21.
        queue_src(1, 40, 21, 6);
        expect_frame(1, 40, 21, 6);
        wait_drain("underrun_drain", 200);
        cycles(40);
        check("underrun_src_consumed", 32'(src1.size()), 32'd0);
        check("underrun_idle", {31'b0, busy}, 32'd0);

        // Oversize: 150-byte frame, then a legal frame of exactly MAXB bytes.
        queue_src(0, 150, 0, 7);
        expect_frame(0, 150, 0, 7);
        wait_drain("oversize_drain", 300);
        cycles(70);
        check("oversize_src_consumed", 32'(src0.size()), 32'd0);
        check("oversize_idle", {31'b0, busy}, 32'd0);
        queue_src(0, MAXB, 0, 8);
        expect_frame(0, MAXB, 0, 8);
        wait_drain("maxlen_drain", 300);
        cycles(16);

        // Link down while idle: no grant until the link returns.
        link_up = 1'b0;
        queue_src(0, 64, 0, 9);
        cycles(20);
        check("link_down_idle", {29'b0, grant, busy}, 32'd0);
        link_up = 1'b1;
        expect_frame(0, 64, 0, 9);
        wait_drain("link_up_drain", 200);
        cycles(16);

        // Link falls mid-frame: frame completes, then no new grant while down.
        beats = 0;
        queue_src(0, 64, 0, 10);
        expect_frame(0, 64, 0, 10);
        wait_beats("link_mid_wait", 10, 100);
        link_up = 1'b0;
        queue_src(1, 64, 0, 11);
        wait_drain("link_mid_drain", 200);
        cycles(30);
        check("link_mid_hold", {29'b0, grant, busy}, 32'd0);
        link_up = 1'b1;
        expect_frame(1, 64, 0, 11);
        wait_drain("link_resume_drain", 200);
        cycles(16);

        // Reset at byte 30: wire goes quiet, pointer returns to 0 so requester 0 wins next.
        beats = 0;
        queue_src(0, 64, 0, 12);
        expect_frame(0, 64, 0, 12);
        wait_beats("reset_mid_wait", 30, 100);
        reset = 1'b1;
        sb.delete();
        src0.delete();
        cycles(1);
        check("reset_mid", {26'b0, grant, req_ready, gmii_tx_en, busy}, 32'd0);
        reset = 1'b0;
        cycles(2);
        queue_src(0, 64, 0, 13);
        queue_src(1, 64, 0, 14);
        expect_frame(0, 64, 0, 13);
        expect_frame(1, 64, 0, 14);
        wait_drain("post_reset_drain", 400);
        cycles(16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
